// File: rtl/mps_mc_sequencer_if.sv
// MPS contactor sequencer bus: command/status and contactor I/O.
// master = register bank / harness side, slave = sequencer side.
interface mps_mc_sequencer_if;
    logic       i_on;
    logic       i_off;
    logic       i_fault_clr;
    logic       i_interlock;
    logic       i_dc_link_ok;
    logic       i_main_mc_fb;
    logic       i_slow_mc_fb;
    logic       o_main_mc;
    logic       o_slow_charge_mc;
    logic       o_discharge_mc;
    logic [2:0] o_state;
    logic       o_ready;
    logic [2:0] o_fault_code;

    modport master (
        output i_on, i_off, i_fault_clr, i_interlock,
        output i_dc_link_ok, i_main_mc_fb, i_slow_mc_fb,
        input  o_main_mc, o_slow_charge_mc, o_discharge_mc,
        input  o_state, o_ready, o_fault_code
    );

    modport slave (
        input  i_on, i_off, i_fault_clr, i_interlock,
        input  i_dc_link_ok, i_main_mc_fb, i_slow_mc_fb,
        output o_main_mc, o_slow_charge_mc, o_discharge_mc,
        output o_state, o_ready, o_fault_code
    );
endinterface

// File: rtl/mps_mc_sequencer.sv
// MPS contactor sequencer: power-up/run/power-down/fault paths with
// break-before-make dead time, charge timeout and aux-contact supervision.
module mps_mc_sequencer #(
    parameter int unsigned CHG_TIMEOUT = 100_000_000,
    parameter int unsigned OVERLAP     = 10_000_000,
    parameter int unsigned DEAD_TIME   = 1_000_000,
    parameter int unsigned DISCH_TIME  = 50_000_000,
    parameter int unsigned FB_TIMEOUT  = 5_000_000
) (
    input  logic              S_AXI_ACLK,
    input  logic              S_AXI_ARESETN,
    mps_mc_sequencer_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_SLOW_CHG   = 3'd1,
        S_MAIN_ON    = 3'd2,
        S_RUN        = 3'd3,
        S_DEAD       = 3'd4,
        S_DISCHARGE  = 3'd5,
        S_FAULT_DEAD = 3'd6,
        S_FAULT      = 3'd7
    } state_e;

    localparam logic [31:0] CHG_LAST = 32'(CHG_TIMEOUT - 32'd1);
    localparam logic [31:0] OVL_LAST = 32'(OVERLAP - 32'd1);
    localparam logic [31:0] DT_LAST  = 32'(DEAD_TIME - 32'd1);
    localparam logic [31:0] DIS_LAST = 32'(DISCH_TIME - 32'd1);
    localparam logic [31:0] FB_LAST  = 32'(FB_TIMEOUT - 32'd1);

    state_e      state_q, state_d;
    logic [31:0] timer_q, timer_d;
    logic [31:0] fbm_q, fbm_d;
    logic [31:0] fbs_q, fbs_d;
    logic [2:0]  code_q, code_d;
    logic        main_q, main_d;
    logic        slow_q, slow_d;
    logic        disch_q, disch_d;
    logic        ready_q, ready_d;
    logic        on_q, on_d;
    logic        off_q, off_d;
    logic        clr_q, clr_d;
    logic        armed_q, armed_d;

    logic on_edge, off_edge, clr_edge;
    logic sup_en, fbm_bad, fbs_bad, flt_main, flt_slow;

    // Request edge detectors and feedback mismatch detection.
    // armed_q masks the first cycle after reset so a level held
    // through reset never reads as a fresh request.
    always_comb begin
        on_d     = bus.i_on;
        off_d    = bus.i_off;
        clr_d    = bus.i_fault_clr;
        armed_d  = 1'b1;
        on_edge  = armed_q & bus.i_on & ~on_q;
        off_edge = armed_q & bus.i_off & ~off_q;
        clr_edge = armed_q & bus.i_fault_clr & ~clr_q;
        sup_en   = (state_q != S_FAULT_DEAD) && (state_q != S_FAULT);
        fbm_bad  = bus.i_main_mc_fb != main_q;
        fbs_bad  = bus.i_slow_mc_fb != slow_q;
        flt_main = sup_en && fbm_bad && (fbm_q >= FB_LAST);
        flt_slow = sup_en && fbs_bad && (fbs_q >= FB_LAST);
    end

    // Next-state and fault-code logic; fault beats i_off beats i_on.
    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        if (sup_en && (bus.i_interlock || flt_main || flt_slow)) begin
            state_d = S_FAULT_DEAD;
            if (bus.i_interlock) begin
                code_d = 3'd2;
            end else if (flt_main) begin
                code_d = 3'd3;
            end else begin
                code_d = 3'd4;
            end
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (on_edge) state_d = S_SLOW_CHG;
                end
                S_SLOW_CHG: begin
                    if (off_edge) begin
                        state_d = S_DEAD;
                    end else if (bus.i_dc_link_ok) begin
                        state_d = S_MAIN_ON;
                    end else if (timer_q == CHG_LAST) begin
                        state_d = S_FAULT_DEAD;
                        code_d  = 3'd1;
                    end
                end
                S_MAIN_ON: begin
                    if (off_edge) begin
                        state_d = S_DEAD;
                    end else if (timer_q == OVL_LAST) begin
                        state_d = S_RUN;
                    end
                end
                S_RUN: begin
                    if (off_edge) state_d = S_DEAD;
                end
                S_DEAD: begin
                    if (timer_q == DT_LAST) state_d = S_DISCHARGE;
                end
                S_DISCHARGE: begin
                    if (timer_q == DIS_LAST) state_d = S_IDLE;
                end
                S_FAULT_DEAD: begin
                    if (timer_q == DT_LAST) state_d = S_FAULT;
                end
                S_FAULT: begin
                    if (clr_edge && !bus.i_interlock &&
                        timer_q >= DIS_LAST) begin
                        state_d = S_IDLE;
                        code_d  = 3'd0;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // State timer, Moore output decode of the next state, and
    // per-contactor mismatch counters.
    always_comb begin
        timer_d = '0;
        if (state_d == state_q) begin
            timer_d = (timer_q == '1) ? timer_q : timer_q + 32'd1;
        end
        main_d  = 1'b0;
        slow_d  = 1'b0;
        disch_d = 1'b0;
        unique case (state_d)
            S_IDLE:       disch_d = 1'b1;
            S_SLOW_CHG:   slow_d  = 1'b1;
            S_MAIN_ON: begin
                main_d = 1'b1;
                slow_d = 1'b1;
            end
            S_RUN:        main_d  = 1'b1;
            S_DEAD:       disch_d = 1'b0;
            S_DISCHARGE:  disch_d = 1'b1;
            S_FAULT_DEAD: disch_d = 1'b0;
            S_FAULT:      disch_d = 1'b1;
            default:      disch_d = 1'b1;
        endcase
        ready_d = state_d == S_RUN;
        fbm_d   = '0;
        if (sup_en && fbm_bad && (main_d == main_q)) begin
            fbm_d = (fbm_q == '1) ? fbm_q : fbm_q + 32'd1;
        end
        fbs_d = '0;
        if (sup_en && fbs_bad && (slow_d == slow_q)) begin
            fbs_d = (fbs_q == '1) ? fbs_q : fbs_q + 32'd1;
        end
    end

    // Registers; reset parks in IDLE with only the discharge MC closed.
    always_ff @(posedge S_AXI_ACLK) begin
        if (!S_AXI_ARESETN) begin
            state_q <= S_IDLE;
            timer_q <= '0;
            fbm_q   <= '0;
            fbs_q   <= '0;
            code_q  <= '0;
            main_q  <= 1'b0;
            slow_q  <= 1'b0;
            disch_q <= 1'b1;
            ready_q <= 1'b0;
            on_q    <= 1'b0;
            off_q   <= 1'b0;
            clr_q   <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            fbm_q   <= fbm_d;
            fbs_q   <= fbs_d;
            code_q  <= code_d;
            main_q  <= main_d;
            slow_q  <= slow_d;
            disch_q <= disch_d;
            ready_q <= ready_d;
            on_q    <= on_d;
            off_q   <= off_d;
            clr_q   <= clr_d;
            armed_q <= armed_d;
        end
    end

    assign bus.o_state          = state_q;
    assign bus.o_main_mc        = main_q;
    assign bus.o_slow_charge_mc = slow_q;
    assign bus.o_discharge_mc   = disch_q;
    assign bus.o_ready          = ready_q;
    assign bus.o_fault_code     = code_q;

endmodule
